// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Receive-side byte buffer placed after uart_receiver. Every cycle i_RX_DONE
// is high one byte is pushed into a power-of-two circular FIFO. Bytes leave
// through a first-word-fall-through valid/ready port. When a byte arrives with
// the FIFO full and no pop in the same cycle, it is dropped. The drop raises a
// sticky overrun flag and bumps a saturating drop counter.
//
// Ports
//   i_CLK          clock, rising edge
//   i_RST_N        asynchronous active-low reset
//   i_RX_DONE      push strobe (level, one push per high cycle)
//   i_RX_DATA      byte to push
//   o_VALID        head entry available (== !o_EMPTY)
//   o_DATA         head entry, 0 when empty
//   i_READY        consumer takes head entry when o_VALID is high
//   o_COUNT        occupancy, 0..2^DEPTH_LOG2
//   o_EMPTY        o_COUNT == 0
//   o_FULL         o_COUNT == 2^DEPTH_LOG2
//   o_OVERRUN      sticky, set on a dropped byte
//   o_DROP_COUNT   saturating number of dropped bytes
//   i_CLR_OVERRUN  synchronous clear of o_OVERRUN / o_DROP_COUNT
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_CLK,
    input  logic                  i_RST_N,
    input  logic                  i_RX_DONE,
    input  logic [DATA_WIDTH-1:0] i_RX_DATA,
    output logic                  o_VALID,
    output logic [DATA_WIDTH-1:0] o_DATA,
    input  logic                  i_READY,
    output logic [DEPTH_LOG2:0]   o_COUNT,
    output logic                  o_EMPTY,
    output logic                  o_FULL,
    output logic                  o_OVERRUN,
    output logic [7:0]            o_DROP_COUNT,
    input  logic                  i_CLR_OVERRUN
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] wp_q, wp_d;
    logic [DEPTH_LOG2-1:0] rp_q, rp_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overrun_q, overrun_d;
    logic [7:0]            drop_q, drop_d;

    logic empty, full, pop, push_ok, drop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == FULL_CNT);
        pop     = !empty && i_READY;
        // A pop in the same cycle frees a slot, so a full FIFO still accepts.
        push_ok = i_RX_DONE && (!full || pop);
        drop    = i_RX_DONE && full && !pop;

        wp_d = push_ok ? wp_q + 1'b1 : wp_q;
        rp_d = pop     ? rp_q + 1'b1 : rp_q;

        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 1'b1;
        end

        // A drop in the clearing cycle is kept: the new event wins.
        overrun_d = overrun_q;
        drop_d    = drop_q;
        if (i_CLR_OVERRUN) begin
            overrun_d = 1'b0;
            drop_d    = 8'd0;
        end
        if (drop) begin
            overrun_d = 1'b1;
            if (i_CLR_OVERRUN) begin
                drop_d = 8'd1;
            end else if (drop_q != 8'hFF) begin
                drop_d = drop_q + 8'd1;
            end
        end
    end

    // Storage is not reset; the empty gate on o_DATA hides stale entries.
    always_ff @(posedge i_CLK) begin
        if (push_ok) begin
            mem_q[wp_q] <= i_RX_DATA;
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            wp_q      <= '0;
            rp_q      <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            drop_q    <= 8'd0;
        end else begin
            wp_q      <= wp_d;
            rp_q      <= rp_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            drop_q    <= drop_d;
        end
    end

    assign o_VALID      = !empty;
    assign o_DATA       = empty ? '0 : mem_q[rp_q];
    assign o_COUNT      = count_q;
    assign o_EMPTY      = empty;
    assign o_FULL       = full;
    assign o_OVERRUN    = overrun_q;
    assign o_DROP_COUNT = drop_q;

endmodule
